// File: rtl/wb_gps_multich_regs.sv
// Wishbone register file for a multi-channel GPS tracking engine: NCO/config out, coherent
// correlator snapshots and sticky status in. Define GPS_WB_IRQ_EN to build IRQ_MASK and irq_o.
module wb_gps_multich_regs #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned FREQ_W      = 30,
  parameter int unsigned CORR_W      = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [9:0]                   wb_adr_i,
  input  logic [31:0]                  wb_dat_i,
  output logic [31:0]                  wb_dat_o,
  input  logic                         wb_we_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_cyc_i,
  output logic                         wb_ack_o,
  output logic [NUM_CH*FREQ_W-1:0]     code_frequency,
  output logic [NUM_CH*FREQ_W-1:0]     carr_frequency,
  output logic [NUM_CH*FREQ_W-1:0]     code_frequency_offset,
  output logic [NUM_CH*FREQ_W-1:0]     carr_frequency_offset,
  output logic [NUM_CH*24-1:0]         sine_lut,
  output logic [NUM_CH*5-1:0]          satellite_id,
  output logic [14:0]                  acq_threshold,
  input  logic [NUM_CH*6*CORR_W-1:0]   corr_data,
  input  logic [NUM_CH-1:0]            intg_ready,
  input  logic                         acq_complete,
  output logic                         irq_o
);

  typedef logic [FREQ_W-1:0] freq_t;

  freq_t                    code_freq_q [NUM_CH], code_freq_d [NUM_CH];
  freq_t                    carr_freq_q [NUM_CH], carr_freq_d [NUM_CH];
  freq_t                    code_off_q [NUM_CH], code_off_d [NUM_CH];
  freq_t                    carr_off_q [NUM_CH], carr_off_d [NUM_CH];
  logic [23:0]              lut_q [NUM_CH], lut_d [NUM_CH];
  logic [4:0]               sat_q [NUM_CH], sat_d [NUM_CH];
  logic [5:0][CORR_W-1:0]   shadow_q [NUM_CH], shadow_d [NUM_CH];
  logic [NUM_CH-1:0]        sync_q [SYNC_STAGES], sync_d [SYNC_STAGES];
  logic [NUM_CH-1:0]        edge_q, edge_d, evt;
  logic [NUM_CH-1:0]        ready_q, ready_d, ovr_q, ovr_d;
  logic [14:0]              thr_q, thr_d;
  logic                     ack_q, ack_d;
  logic [31:0]              dat_q, dat_d;
  logic                     req, wr;
  logic [3:0]               page, idx;
  logic [31:0]              rdata;
  logic                     unused_bits;
`ifdef GPS_WB_IRQ_EN
  logic [NUM_CH-1:0]        mask_rdy_q, mask_rdy_d, mask_ovr_q, mask_ovr_d;
  logic                     irq_q, irq_d;
`endif

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:29]};

  function automatic logic [31:0] sext(input logic [CORR_W-1:0] v);
    return 32'($signed(v));
  endfunction

  always_comb begin
    req   = wb_cyc_i & wb_stb_i & ~ack_q;
    wr    = req & wb_we_i;
    page  = wb_adr_i[9:6];
    idx   = wb_adr_i[5:2];
    ack_d = req;
    rdata = '0;

    code_freq_d = code_freq_q;
    carr_freq_d = carr_freq_q;
    code_off_d  = code_off_q;
    carr_off_d  = carr_off_q;
    lut_d       = lut_q;
    sat_d       = sat_q;
    shadow_d    = shadow_q;
    ready_d     = ready_q;
    ovr_d       = ovr_q;
    thr_d       = thr_q;
`ifdef GPS_WB_IRQ_EN
    mask_rdy_d  = mask_rdy_q;
    mask_ovr_d  = mask_ovr_q;
    irq_d       = |((ready_q & mask_rdy_q) | (ovr_q & mask_ovr_q));
`endif

    // Falling edge of the synchronised intg_ready marks the end of an integration.
    sync_d[0] = intg_ready;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    edge_d = sync_q[SYNC_STAGES-1];
    evt    = edge_q & ~sync_q[SYNC_STAGES-1];

    for (int c = 0; c < NUM_CH; c++) begin
      if (page == 4'(c)) begin
        case (idx)
          4'd0: begin
            rdata = 32'(code_freq_q[c]);
            if (wr) code_freq_d[c] = wb_dat_i[FREQ_W-1:0];
          end
          4'd1: begin
            rdata = 32'(carr_freq_q[c]);
            if (wr) carr_freq_d[c] = wb_dat_i[FREQ_W-1:0];
          end
          4'd2: begin
            rdata = 32'(code_off_q[c]);
            if (wr) code_off_d[c] = wb_dat_i[FREQ_W-1:0];
          end
          4'd3: begin
            rdata = 32'(carr_off_q[c]);
            if (wr) carr_off_d[c] = wb_dat_i[FREQ_W-1:0];
          end
          4'd4: begin
            rdata = {3'b0, sat_q[c], lut_q[c]};
            if (wr) begin
              lut_d[c] = wb_dat_i[23:0];
              sat_d[c] = wb_dat_i[28:24];
            end
          end
          4'd5:  rdata = sext(shadow_q[c][0]);
          4'd6:  rdata = sext(shadow_q[c][1]);
          4'd7:  rdata = sext(shadow_q[c][2]);
          4'd8:  rdata = sext(shadow_q[c][3]);
          4'd9:  rdata = sext(shadow_q[c][4]);
          4'd10: rdata = sext(shadow_q[c][5]);
          default: ;
        endcase
      end
      // Reads above use shadow_q, so a same-cycle capture returns the old snapshot.
      if (evt[c]) shadow_d[c] = corr_data[c*6*CORR_W +: 6*CORR_W];
    end

    if (page == 4'hF) begin
      case (idx)
        4'd0: begin
          rdata = {17'b0, thr_q};
          if (wr) thr_d = wb_dat_i[14:0];
        end
        4'd1: begin
          rdata = {acq_complete, 7'b0, 8'(ovr_q), 8'b0, 8'(ready_q)};
          if (wr) begin
            ready_d = ready_d & ~wb_dat_i[NUM_CH-1:0];
            ovr_d   = ovr_d & ~wb_dat_i[16 +: NUM_CH];
          end
        end
`ifdef GPS_WB_IRQ_EN
        4'd2: begin
          rdata = {8'b0, 8'(mask_ovr_q), 8'b0, 8'(mask_rdy_q)};
          if (wr) begin
            mask_rdy_d = wb_dat_i[NUM_CH-1:0];
            mask_ovr_d = wb_dat_i[16 +: NUM_CH];
          end
        end
`endif
        4'd3: rdata = {16'h6750, 8'h01, 8'(NUM_CH)};
        default: ;
      endcase
    end

    // Applied after the W1C so a coincident event keeps its bit set.
    ovr_d   = ovr_d | (evt & ready_q);
    ready_d = ready_d | evt;

    dat_d = req ? rdata : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      code_freq_q <= '{default: '0};
      carr_freq_q <= '{default: '0};
      code_off_q  <= '{default: '0};
      carr_off_q  <= '{default: '0};
      lut_q       <= '{default: '0};
      sat_q       <= '{default: '0};
      shadow_q    <= '{default: '0};
      sync_q      <= '{default: '0};
      edge_q      <= '0;
      ready_q     <= '0;
      ovr_q       <= '0;
      thr_q       <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
`ifdef GPS_WB_IRQ_EN
      mask_rdy_q  <= '0;
      mask_ovr_q  <= '0;
      irq_q       <= 1'b0;
`endif
    end else begin
      code_freq_q <= code_freq_d;
      carr_freq_q <= carr_freq_d;
      code_off_q  <= code_off_d;
      carr_off_q  <= carr_off_d;
      lut_q       <= lut_d;
      sat_q       <= sat_d;
      shadow_q    <= shadow_d;
      sync_q      <= sync_d;
      edge_q      <= edge_d;
      ready_q     <= ready_d;
      ovr_q       <= ovr_d;
      thr_q       <= thr_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
`ifdef GPS_WB_IRQ_EN
      mask_rdy_q  <= mask_rdy_d;
      mask_ovr_q  <= mask_ovr_d;
      irq_q       <= irq_d;
`endif
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign code_frequency[c*FREQ_W +: FREQ_W]        = code_freq_q[c];
    assign carr_frequency[c*FREQ_W +: FREQ_W]        = carr_freq_q[c];
    assign code_frequency_offset[c*FREQ_W +: FREQ_W] = code_off_q[c];
    assign carr_frequency_offset[c*FREQ_W +: FREQ_W] = carr_off_q[c];
    assign sine_lut[c*24 +: 24]                      = lut_q[c];
    assign satellite_id[c*5 +: 5]                    = sat_q[c];
  end

  assign wb_ack_o      = ack_q;
  assign wb_dat_o      = dat_q;
  assign acq_threshold = thr_q;
`ifdef GPS_WB_IRQ_EN
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule
